// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: state codes, opcode
// constants and next-PC source selects.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ECALL  = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4 = 2'd0,
        PC_SEL_IMM   = 2'd1,
        PC_SEL_RS1   = 2'd2
    } pc_sel_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_ILOAD  = 7'b0000011;
    localparam logic [6:0] OP_STYPE  = 7'b0100011;
    localparam logic [6:0] OP_BTYPE  = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_IARITH, OP_ILOAD, OP_STYPE, OP_BTYPE,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ECALL: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Handshake and control bundle between the sequencer (master) and the
// datapath / memories / IO unit it drives (slave).
interface cpu_sequencer_if;
    import cpu_sequencer_pkg::*;

    logic        start;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        branch_taken;
    logic        ecall_done;

    logic        imem_req;
    logic        ir_we;
    logic        reg_write;
    logic        dmem_re;
    logic        dmem_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        ecall_req;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] instret;

    modport master (
        input  start, opcode, imem_ready, dmem_ready, branch_taken, ecall_done,
        output imem_req, ir_we, reg_write, dmem_re, dmem_we, pc_we, pc_sel,
               ecall_req, halted, state, instret
    );

    modport slave (
        output start, opcode, imem_ready, dmem_ready, branch_taken, ecall_done,
        input  imem_req, ir_we, reg_write, dmem_re, dmem_we, pc_we, pc_sel,
               ecall_req, halted, state, instret
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cpu_sequencer_if.master bus
);

    state_e      state_q;
    state_e      state_d;
    state_e      out_state_s;
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    logic        imem_req_s;
    logic        ir_we_s;
    logic        reg_write_s;
    logic        dmem_re_s;
    logic        dmem_we_s;
    logic        pc_we_s;
    pc_sel_e     pc_sel_s;
    logic        ecall_req_s;

    // state and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_FETCH;
                else           state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.imem_ready) state_d = ST_DECODE;
                else                state_d = ST_FETCH;
            end
            ST_DECODE: begin
                if (bus.opcode == OP_ECALL)      state_d = ST_ECALL;
                else if (!is_legal_op(bus.opcode)) state_d = ST_HALT;
                else                             state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if ((bus.opcode == OP_ILOAD) || (bus.opcode == OP_STYPE)) state_d = ST_MEM;
                else if (bus.opcode == OP_BTYPE)                          state_d = ST_FETCH;
                else                                                      state_d = ST_WB;
            end
            ST_MEM: begin
                if (!bus.dmem_ready)             state_d = ST_MEM;
                else if (bus.opcode == OP_ILOAD) state_d = ST_WB;
                else                             state_d = ST_FETCH;
            end
            ST_WB:    state_d = ST_FETCH;
            ST_ECALL: begin
                if (bus.ecall_done) state_d = ST_FETCH;
                else                state_d = ST_ECALL;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // while reset is asserted the strobes decode as if idle, so nothing fires
    always_comb begin
        if (rst) out_state_s = state_q;
        else     out_state_s = ST_IDLE;
    end

    // control strobes for the current state and handshake inputs
    always_comb begin
        imem_req_s  = 1'b0;
        ir_we_s     = 1'b0;
        reg_write_s = 1'b0;
        dmem_re_s   = 1'b0;
        dmem_we_s   = 1'b0;
        pc_we_s     = 1'b0;
        pc_sel_s    = PC_SEL_PLUS4;
        ecall_req_s = 1'b0;
        case (out_state_s)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                ir_we_s    = bus.imem_ready;
            end
            ST_EXEC: begin
                pc_we_s = (bus.opcode == OP_BTYPE);
                if ((bus.opcode == OP_BTYPE) && bus.branch_taken) pc_sel_s = PC_SEL_IMM;
                else                                              pc_sel_s = PC_SEL_PLUS4;
            end
            ST_MEM: begin
                dmem_re_s = (bus.opcode == OP_ILOAD);
                dmem_we_s = (bus.opcode == OP_STYPE);
                pc_we_s   = (bus.opcode == OP_STYPE) && bus.dmem_ready;
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                pc_we_s     = 1'b1;
                case (bus.opcode)
                    OP_JAL:  pc_sel_s = PC_SEL_IMM;
                    OP_JALR: pc_sel_s = PC_SEL_RS1;
                    default: pc_sel_s = PC_SEL_PLUS4;
                endcase
            end
            ST_ECALL: begin
                ecall_req_s = 1'b1;
                pc_we_s     = bus.ecall_done;
            end
            default: pc_sel_s = PC_SEL_PLUS4;
        endcase
    end

    // an instruction retires exactly when the PC is updated
    always_comb begin
        if (pc_we_s) instret_d = instret_q + 32'd1;
        else         instret_d = instret_q;
    end

    assign bus.imem_req  = imem_req_s;
    assign bus.ir_we     = ir_we_s;
    assign bus.reg_write = reg_write_s;
    assign bus.dmem_re   = dmem_re_s;
    assign bus.dmem_we   = dmem_we_s;
    assign bus.pc_we     = pc_we_s;
    assign bus.pc_sel    = pc_sel_s;
    assign bus.ecall_req = ecall_req_s;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.state     = state_q;
    assign bus.instret   = instret_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Reset rst, synchronous, active-low; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset.
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 opcode  input  7  opcode of the latched instruction; valid from DECODE onward.
REQ-006 imem_ready  input  1  instruction memory has returned the word requested by imem_req.
REQ-007 dmem_ready  input  1  data memory has completed the access requested by dmem_re or dmem_we.
REQ-008 branch_taken  input  1  ALU branch compare result; sampled in EXEC.
REQ-009 ecall_done  input  1  IO unit has finished servicing the ecall.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 ir_we  output  1  latch instruction register.
REQ-012 reg_write  output  1  register-file write strobe; drives the register file's Write port.
REQ-013 dmem_re / dmem_we  output  1 each  data-memory read and write requests.
REQ-014 pc_we  output  1  update the program counter.
REQ-015 pc_sel  output  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm.
REQ-016 ecall_req  output  1  ecall service request to the IO unit.
REQ-017 halted  output  1  sequencer is stopped on an illegal opcode.
REQ-018 state  output  3  current state encoding, for debug.
REQ-019 instret  output  32  count of retired instructions.

Function
REQ-020 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ECALL=6, HALT=7.
REQ-021 IDLE: when start=1, go to FETCH on the next cycle; otherwise stay in IDLE.
REQ-022 FETCH: hold imem_req=1 until imem_ready=1. In the imem_ready cycle, pulse ir_we=1 and go to DECODE.
REQ-023 DECODE lasts 1 cycle. Next state is ECALL for ECALL, HALT for an opcode outside the ten defined opcodes, and EXEC for all others.
REQ-024 EXEC lasts 1 cycle.
  - ILOAD and STYPE: next state is MEM.
  - BTYPE: pc_we=1 this cycle, pc_sel=1 if branch_taken else 0; next state is FETCH (instruction retires).
  - All other opcodes: next state is WB.
REQ-025 MEM: assert dmem_re (ILOAD) or dmem_we (STYPE) until dmem_ready=1.
  - ILOAD: on dmem_ready, go to WB.
  - STYPE: on dmem_ready, pc_we=1 with pc_sel=0, go to FETCH (instruction retires).
REQ-026 WB lasts 1 cycle: reg_write=1 and pc_we=1, then go to FETCH.
  - pc_sel=1 for JAL, 2 for JALR, 0 otherwise.
REQ-027 ECALL: hold ecall_req=1 until ecall_done=1. On ecall_done, pc_we=1 with pc_sel=0, go to FETCH (instruction retires).
REQ-028 HALT is absorbing: halted=1, all strobes 0. Only reset exits HALT.
REQ-029 All outputs other than state, instret and halted are combinational from the state, opcode and handshake inputs, and are 0 in every state or cycle not listed above.
REQ-030 instret increments by 1 in each cycle where an instruction retires, i.e. pc_we=1. It wraps from 0xFFFFFFFF to 0.
REQ-031 imem_ready in any state other than FETCH, dmem_ready outside MEM, and ecall_done outside ECALL are ignored.
REQ-032 The ready inputs may arrive in the same cycle as their request is first asserted, giving zero wait states.
REQ-033 start is ignored outside IDLE.

Reset
REQ-034 rst=0 at a clock edge forces state=IDLE and instret=0 from any state, including mid-FETCH, mid-MEM and HALT.
REQ-035 While in reset and in IDLE, all outputs are 0.
REQ-036 An outstanding memory request is dropped on reset; the memories must tolerate a deasserted request.

Structure
REQ-037 Opcode constants (RTYPE, IARITH, ILOAD, STYPE, BTYPE, JAL, JALR, LUI, AUIPC, ECALL), the state encodings and the pc_sel encodings live in the shared variables header.
REQ-038 The block is a single module with no sub-modules. The instret counter is inline.

Verification
REQ-039 Reset, then start=1 with an RTYPE word and imem_ready held 1:
  - Expected state sequence: FETCH, DECODE, EXEC, WB, FETCH.
  - reg_write=1 exactly one cycle; instret=1.
REQ-040 ILOAD with dmem_ready delayed 3 cycles:
  - dmem_re high for exactly 4 cycles, then WB with reg_write=1.
  - STYPE under the same stimulus gives dmem_we with no reg_write.
REQ-041 BTYPE:
  - branch_taken=1 gives pc_sel=1 and pc_we=1 in EXEC, with reg_write=0.
  - branch_taken=0 gives pc_sel=0.
REQ-042 Opcode 7'b1111111: HALT reached after DECODE, halted=1. It stays halted for 20 cycles with start toggling. rst=0 returns the sequencer to IDLE.
REQ-043 ECALL, with ecall_done asserted after 5 cycles: ecall_req is high for 6 cycles, then FETCH, and instret increments by 1.
REQ-044 Preload instret to 0xFFFFFFFF by force, then retire one instruction: instret=0. Separately, asserting rst=0 mid-MEM gives state=IDLE and dmem_re=0 on the next cycle.
